pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
Writer end of the image-memory path. The block accepts a byte stream of pixels and writes each pixel into a two-bank image memory. Bank b holds one frame at base address b*IN_WIDTH. After a bank is full it is handed to the reader side (memory reader feeding neural_net) through a valid/ack pair. The block gives ping-pong buffering, so the next frame can load while the current one is classified.

Parameters:
IN_WIDTH, 784, pixels per frame (bytes per bank)
DATA_W, 8, pixel width
ADDR_W, $clog2(2*IN_WIDTH), memory address width (11 at default)

Ports:
clk  in  1  system clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream pixel valid
s_data  in  DATA_W  upstream pixel byte
s_last  in  1  upstream end-of-frame marker, qualified by s_valid
s_ready  out  1  block can accept a pixel this cycle
wr_en  out  1  memory write strobe (registered)
wr_addr  out  ADDR_W  memory write address (registered)
wr_data  out  DATA_W  memory write data (registered)
frame_valid  out  1  bank rd_bank holds a complete frame
rd_base  out  ADDR_W  base address of the ready bank (0 or IN_WIDTH)
frame_ack  in  1  reader has consumed the ready bank; honoured only when frame_valid=1
frame_err  out  1  one-cycle pulse: a frame was dropped on a length mismatch

Behaviour:
- Reset values (asynchronous, while rst_n=0): s_ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, rd_base=0, frame_err=0, pix_cnt=0, wr_bank=0, rd_bank=0, bank_full=2'b00. Reset mid-frame discards the partial frame and both full banks.
- Handshake: a pixel is accepted when s_valid & s_ready on a rising edge. s_ready = (state==FILL) & ~bank_full[wr_bank]. s_ready is not combinationally dependent on s_valid.
- Write latency: a pixel accepted in cycle T produces wr_en=1, wr_addr=wr_bank*IN_WIDTH+pix_cnt and wr_data=s_data during cycle T+1.
- pix_cnt: runs 0..IN_WIDTH-1 and increments on each accept. On an accept with pix_cnt==IN_WIDTH-1:
  - pix_cnt wraps to 0;
  - wr_bank toggles;
  - a completion for the old bank is pending.
- The pending completion sets bank_full[old bank] at the end of T+1, after the last write is committed. frame_valid therefore first rises in T+2.
- frame_valid = bank_full[rd_bank]. rd_base = rd_bank*IN_WIDTH.
- Ack: frame_ack while frame_valid clears bank_full[rd_bank] and toggles rd_bank on that edge. frame_ack while frame_valid=0 is ignored.
- Simultaneous completion and ack in the same cycle: both take effect. They always target different banks, so no conflict.
- Both banks full: s_ready=0 until an ack frees the bank at wr_bank. s_ready then rises in the cycle after the ack edge.
- State machine: two states, FILL and WAIT_FREE.
  - FILL -> WAIT_FREE when a frame completes and the next bank (new wr_bank) is full, or will be full once its pending completion is set.
  - WAIT_FREE -> FILL when bank_full[wr_bank] clears.
- s_last rules:
  - s_last on pixel IN_WIDTH-1: normal completion.
  - s_last on an accepted pixel with pix_cnt<IN_WIDTH-1: the frame is dropped. That pixel is not written, pix_cnt returns to 0, wr_bank is unchanged, bank_full is untouched, and frame_err pulses in T+1.
  - s_last absent on pixel IN_WIDTH-1: the frame still completes, and counting restarts at 0.
- Address arithmetic is unsigned ADDR_W. The maximum address is 2*IN_WIDTH-1 (1567 at default). The block never writes outside a bank.

Decomposition:
- Package pixel_frame_pkg holds:
  - IN_WIDTH_DEFAULT=784 and NUM_BANKS=2;
  - typedef pixel_t = logic [7:0];
  - typedef enum {FILL, WAIT_FREE} wr_state_e.
- One natural sub-module: frame_bank_tracker. It holds bank_full, rd_bank and the ack/complete update logic. Counter, state machine and write registers stay in the top.

Test Plan:
1. Reset, then stream 784 bytes (value = index mod 256) with s_valid held high and no ack -> wr_addr goes 0..783 with wr_data matching; frame_valid=1 at the 2nd cycle after the last accept; rd_base=0.
2. Continue with a second 784-byte frame, still no ack -> writes go to 784..1567; afterwards s_ready=0, frame_valid=1, rd_base=0. Then pulse frame_ack -> rd_base=784, frame_valid stays 1, and s_ready=1 the next cycle.
3. Send 100 bytes with s_last on the 100th byte -> 99 writes only; frame_err pulses once; no bank_full change. The next 784 bytes write from the base address again.
4. Assert frame_ack on the same edge as the last pixel of bank 1 while bank 0 is valid -> bank 0 is freed, bank 1 is marked full 1 cycle later, and no stall occurs.
5. Drop rst_n asynchronously at pixel 400 -> all outputs return to reset values immediately. After release, a full frame writes to 0..783.
6. Hold frame_ack high while frame_valid=0 -> no state change; and an s_valid toggling pattern 1,0,1 -> only accepted bytes are written, and addresses stay contiguous.

Source files
------------

// File: rtl/pixel_frame_pkg.sv
// pixel_frame_pkg: shared types and constants for the ping-pong pixel frame writer
package pixel_frame_pkg;
    localparam int IN_WIDTH_DEFAULT = 784;
    localparam int NUM_BANKS = 2;
    typedef logic [7:0] pixel_t;
    typedef enum logic {FILL, WAIT_FREE} wr_state_e;
    function automatic int unsigned bank_base(input logic bank, input int unsigned width);
        return bank ? width : 0;
    endfunction
endpackage

// File: rtl/pixel_frame_writer_if.sv
// pixel_frame_writer_if: upstream pixel byte stream with valid/ready handshake
interface pixel_frame_writer_if #(parameter int DATA_W = 8) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/frame_bank_tracker.sv
// frame_bank_tracker: per-bank full flags and read-side pointer with complete/ack updates
module frame_bank_tracker
    import pixel_frame_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEFAULT,
    parameter int ADDR_W = $clog2(2*IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 complete,
    input  logic                 complete_bank,
    input  logic                 ack,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic [NUM_BANKS-1:0] full_nxt,
    output logic                 frame_valid,
    output logic [ADDR_W-1:0]    rd_base
);
    logic rd_bank;
    logic ack_fire;
    assign frame_valid = bank_full[rd_bank];
    assign ack_fire = ack & frame_valid;
    assign rd_base = ADDR_W'(bank_base(rd_bank, IN_WIDTH));
    // completion and ack always address different banks, so both apply together
    always_comb full_nxt = (bank_full | (NUM_BANKS'(complete) << complete_bank))
                         & ~(NUM_BANKS'(ack_fire) << rd_bank);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            rd_bank <= 1'b0;
        end else begin
            bank_full <= full_nxt;
            rd_bank <= rd_bank ^ ack_fire;
        end
    end
endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: writes a pixel byte stream into a two-bank ping-pong image memory
module pixel_frame_writer
    import pixel_frame_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEFAULT,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(2*IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pixel_frame_writer_if.slave  s,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 frame_valid,
    output logic [ADDR_W-1:0]    rd_base,
    input  logic                 frame_ack,
    output logic                 frame_err
);
    localparam int CNT_W = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
    wr_state_e state, state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic wr_bank, comp_pend, comp_bank;
    logic [NUM_BANKS-1:0] bank_full, full_nxt;
    logic accept, end_pix, drop, fin;
    assign accept = s.s_valid & s.s_ready;
    assign end_pix = pix_cnt == CNT_W'(IN_WIDTH-1);
    assign drop = accept & s.s_last & ~end_pix;
    assign fin = accept & end_pix;
    frame_bank_tracker #(.IN_WIDTH(IN_WIDTH), .ADDR_W(ADDR_W)) u_tracker (
        .clk(clk),
        .rst_n(rst_n),
        .complete(comp_pend),
        .complete_bank(comp_bank),
        .ack(frame_ack),
        .bank_full(bank_full),
        .full_nxt(full_nxt),
        .frame_valid(frame_valid),
        .rd_base(rd_base)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else state <= state_nxt;
    end
    // decisions look at next-cycle fullness so an ack on the same edge is honoured
    always_comb state_nxt = (state == FILL) ? ((fin && full_nxt[~wr_bank]) ? WAIT_FREE : FILL)
                                            : (full_nxt[wr_bank] ? WAIT_FREE : FILL);
    always_comb s.s_ready = rst_n & (state == FILL) & ~bank_full[wr_bank];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            wr_bank <= 1'b0;
            comp_pend <= 1'b0;
            comp_bank <= 1'b0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en <= accept & ~drop;
            frame_err <= drop;
            comp_pend <= fin;
            comp_bank <= wr_bank;
            if (accept) begin
                wr_addr <= ADDR_W'(bank_base(wr_bank, IN_WIDTH)) + ADDR_W'(pix_cnt);
                wr_data <= s.s_data;
                pix_cnt <= (drop | end_pix) ? '0 : pix_cnt + 1'b1;
                wr_bank <= wr_bank ^ end_pix;
            end
        end
    end
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: phase table, reset corner and random stream checked against a queue-based model
module tb_pixel_frame_writer;
    import pixel_frame_pkg::*;
    localparam int IW = IN_WIDTH_DEFAULT;
    localparam int AW = $clog2(2*IW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en, frame_valid, frame_err;
    logic frame_ack = 1'b0;
    logic [AW-1:0] wr_addr, rd_base;
    pixel_t wr_data;

    pixel_frame_writer_if #(.DATA_W(8)) s_if ();

    pixel_frame_writer dut (
        .clk(clk),
        .rst_n(rst_n),
        .s(s_if),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_valid(frame_valid),
        .rd_base(rd_base),
        .frame_ack(frame_ack),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int last_idx;
        bit toggle;
        bit ack_last;
        int idle;
        int ack_cyc;
        bit fv;
        int base;
        bit rdy;
        int errs;
    } phase_t;

    phase_t tbl[11];

    // reference model: frames waiting for the reader form a FIFO of bank numbers
    int m_cnt, m_acks, ew_addr, ew_data;
    bit m_wbank, pend_v, pend_b, ew_v, eerr;
    int full_q[$];
    int n_chk = 0, n_fail = 0, err_seen = 0;

    function automatic bit in_q(input bit b);
        foreach (full_q[i]) if (full_q[i] == int'(b)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_acks = 0; m_wbank = 0;
        pend_v = 0; pend_b = 0; ew_v = 0; eerr = 0;
        ew_addr = 0; ew_data = 0;
        full_q.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit v, input pixel_t d, input bit l, input bit a, output bit acc);
        bit fv, rdy, ack;
        int base;
        s_if.s_valid = v; s_if.s_data = d; s_if.s_last = l; frame_ack = a;
        #1;
        rdy = !in_q(m_wbank);
        fv = full_q.size() > 0;
        base = fv ? full_q[0] * IW : (m_acks % 2) * IW;
        chk("s_ready", int'(s_if.s_ready), int'(rdy));
        chk("frame_valid", int'(frame_valid), int'(fv));
        chk("rd_base", int'(rd_base), base);
        chk("wr_en", int'(wr_en), int'(ew_v));
        if (ew_v) begin
            chk("wr_addr", int'(wr_addr), ew_addr);
            chk("wr_data", int'(wr_data), ew_data);
        end
        chk("frame_err", int'(frame_err), int'(eerr));
        if (frame_err) err_seen++;
        acc = v && rdy;
        ack = a && fv;
        @(posedge clk);
        ew_v = 0; eerr = 0;
        if (ack) begin
            void'(full_q.pop_front());
            m_acks++;
        end
        if (pend_v) full_q.push_back(int'(pend_b));
        pend_v = 0;
        if (acc) begin
            if (l && m_cnt < IW-1) begin
                eerr = 1; m_cnt = 0;
            end else begin
                ew_v = 1; ew_addr = int'(m_wbank) * IW + m_cnt; ew_data = int'(d);
                if (m_cnt == IW-1) begin
                    pend_v = 1; pend_b = m_wbank; m_wbank = ~m_wbank; m_cnt = 0;
                end else m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_phase(input int id, input phase_t p);
        int acc_n, cyc, e0;
        bit acc;
        acc_n = 0; cyc = 0; e0 = err_seen;
        while (acc_n < p.n && cyc < 3*p.n + 10) begin
            cycle(p.toggle ? (cyc % 2 == 0) : 1'b1, pixel_t'(acc_n % 256), acc_n == p.last_idx,
                  p.ack_last && acc_n == p.n-1, acc);
            if (acc) acc_n++;
            cyc++;
        end
        chk($sformatf("p%0d_accepts", id), acc_n, p.n);
        if (!p.toggle) chk($sformatf("p%0d_no_stall_cycles", id), cyc, p.n);
        for (int i = 0; i < p.idle; i++) cycle(1'b0, 8'h00, 1'b0, i < p.ack_cyc, acc);
        chk($sformatf("p%0d_frame_valid", id), int'(frame_valid), int'(p.fv));
        chk($sformatf("p%0d_rd_base", id), int'(rd_base), p.base);
        chk($sformatf("p%0d_s_ready", id), int'(s_if.s_ready), int'(p.rdy));
        chk($sformatf("p%0d_err_pulses", id), err_seen - e0, p.errs);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, int'(s_if.s_ready), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_frame_valid"}, int'(frame_valid), 0);
        chk({tag, "_rd_base"}, int'(rd_base), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc, v, l, a;
        phase_t post;
        //           n    last  tog ackl idle ackc fv base  rdy errs
        tbl[0]  = '{784,  -1,   0,  0,   2,   0,   1,  0,   1,  0};
        tbl[1]  = '{784,  783,  0,  0,   2,   0,   1,  0,   0,  0};
        tbl[2]  = '{0,    -1,   0,  0,   1,   1,   1,  784, 1,  0};
        tbl[3]  = '{100,  99,   0,  0,   2,   0,   1,  784, 1,  1};
        tbl[4]  = '{784,  783,  0,  0,   2,   0,   1,  784, 0,  0};
        tbl[5]  = '{0,    -1,   0,  0,   1,   1,   1,  0,   1,  0};
        tbl[6]  = '{784,  783,  0,  1,   2,   0,   1,  784, 1,  0};
        tbl[7]  = '{0,    -1,   0,  0,   1,   1,   0,  0,   1,  0};
        tbl[8]  = '{0,    -1,   0,  0,   4,   4,   0,  0,   1,  0};
        tbl[9]  = '{50,   -1,   1,  0,   1,   0,   0,  0,   1,  0};
        tbl[10] = '{734,  733,  0,  0,   2,   0,   1,  0,   1,  0};
        post    = '{784,  783,  0,  0,   2,   0,   1,  0,   1,  0};

        s_if.s_valid = 0; s_if.s_data = 0; s_if.s_last = 0;
        model_reset();
        #3;
        chk_reset_outputs("init_rst");
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) run_phase(i, tbl[i]);

        // asynchronous reset partway through a frame
        for (int k = 0, c = 0; k < 400 && c < 1000; c++) begin
            cycle(1'b1, pixel_t'(k % 256), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        s_if.s_valid = 0;
        #2 rst_n = 0;
        #1 chk_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        run_phase(99, post);

        for (int c = 0; c < 6000; c++) begin
            v = $urandom_range(0, 9) < 7;
            l = (m_cnt == IW-1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0);
            a = (c < 3000) ? ($urandom_range(0, 799) == 0) : ($urandom_range(0, 19) == 0);
            cycle(v, pixel_t'($urandom), l, a, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
